// File: rtl/prefetch_scheduler_pkg.sv
// prefetch_scheduler_pkg
// Shared types for the prefetch scheduler: the request/ack structs exchanged
// with issuers and the cache, and the line-address type held by the filter.
package prefetch_scheduler_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_OFF = 6;   // 64-byte cache lines

    typedef struct packed {
        logic [ADDR_W-1:0] addr;   // line-aligned byte address
        logic              valid;
    } Prefetch;

    typedef struct packed {
        logic valid;
    } Prefetch_ACK;

    typedef logic [ADDR_W-LINE_OFF-1:0] PFLine_t;

endpackage

// File: rtl/prefetch_scheduler_if.sv
// prefetch_scheduler_if
// Bundles the issuer-side request bus and the cache-side prefetch port.
//   master : issuers + cache (drive IN_*, observe OUT_*)
//   slave  : the scheduler
interface prefetch_scheduler_if
    import prefetch_scheduler_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int MAX_INFLIGHT = 4
);
    Prefetch     [NUM_SRC-1:0]              IN_req;
    logic        [NUM_SRC-1:0]              OUT_reqReady;
    Prefetch                                OUT_prefetch;
    logic                                   IN_prefetchReady;
    Prefetch_ACK                            IN_prefetchAck;
    logic                                   IN_flush;
    logic        [$clog2(MAX_INFLIGHT+1)-1:0] OUT_inflight;

    modport master (
        output IN_req, IN_prefetchReady, IN_prefetchAck, IN_flush,
        input  OUT_reqReady, OUT_prefetch, OUT_inflight
    );

    modport slave (
        input  IN_req, IN_prefetchReady, IN_prefetchAck, IN_flush,
        output OUT_reqReady, OUT_prefetch, OUT_inflight
    );
endinterface

// File: rtl/prefetch_line_filter.sv
// prefetch_line_filter
// Small CAM of recently issued cache lines with FIFO replacement.
// Ports: clk, rst (sync, active-high), clear_i (invalidate all),
//        lookup_line_i -> hit_o (combinational), insert_i/insert_line_i
//        (write at wrPtr, wrPtr advances and wraps at FILTER_SIZE).
module prefetch_line_filter
    import prefetch_scheduler_pkg::*;
#(
    parameter int FILTER_SIZE = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clear_i,
    input  PFLine_t lookup_line_i,
    output logic    hit_o,
    input  logic    insert_i,
    input  PFLine_t insert_line_i
);
    localparam int IDX_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

    PFLine_t [FILTER_SIZE-1:0] line_q;
    logic    [FILTER_SIZE-1:0] vld_q;
    logic    [IDX_W-1:0]       wr_q;

    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < FILTER_SIZE; i++)
            if (vld_q[i] && line_q[i] == lookup_line_i) hit_o = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            wr_q  <= '0;
        end else if (clear_i) begin
            vld_q <= '0;
            wr_q  <= '0;
        end else if (insert_i) begin
            line_q[wr_q] <= insert_line_i;
            vld_q[wr_q]  <= 1'b1;
            wr_q         <= wr_q + IDX_W'(1);
        end
    end
endmodule

// File: rtl/prefetch_scheduler.sv
// prefetch_scheduler
// Round-robin arbiter of prefetch issuers onto the single cache prefetch
// port, with a credit cap on outstanding prefetches. Optional recent-line
// dedup filter enabled by defining PF_DEDUP_FILTER_EN.
// Ports: clk, rst (sync, active-high), bus (prefetch_scheduler_if.slave):
//   IN_req/OUT_reqReady (issuers), OUT_prefetch/IN_prefetchReady (cache),
//   IN_prefetchAck (credit return), IN_flush, OUT_inflight.
module prefetch_scheduler
    import prefetch_scheduler_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int FILTER_SIZE  = 8
) (
    input logic                 clk,
    input logic                 rst,
    prefetch_scheduler_if.slave bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [SRC_W-1:0] rr_q, rr_d;
    Prefetch          pf_q, pf_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic [NUM_SRC-1:0] req_vld;
    logic [SRC_W-1:0]   win;
    logic found, slot_free, ack_eff, hs, inc, credit_ok, grant, hit;

    // Lowest set bit of the request vector rotated to start at rr_q.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_SRC; i++) req_vld[i] = bus.IN_req[i].valid;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && req_vld[(int'(rr_q) + i) % NUM_SRC]) begin
                found = 1'b1;
                win   = SRC_W'((int'(rr_q) + i) % NUM_SRC);
            end
        end
    end

    // An ack at zero inflight is stale (e.g. after reset) and frees nothing.
    assign ack_eff   = bus.IN_prefetchAck.valid && (inflight_q != '0);
    assign slot_free = !pf_q.valid || bus.IN_prefetchReady;
    assign hs        = pf_q.valid && bus.IN_prefetchReady;
    assign inc       = hs && (inflight_q < CNT_W'(MAX_INFLIGHT));
    // The pending output already holds a credit, so count it as outstanding.
    assign credit_ok = ((int'(inflight_q) + int'(pf_q.valid)) < MAX_INFLIGHT) || ack_eff;
    assign grant     = found && slot_free && credit_ok && !bus.IN_flush && !rst;

`ifdef PF_DEDUP_FILTER_EN
    PFLine_t win_line;
    assign win_line = bus.IN_req[win].addr[ADDR_W-1:LINE_OFF];

    prefetch_line_filter #(.FILTER_SIZE(FILTER_SIZE)) u_filter (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (bus.IN_flush),
        .lookup_line_i(win_line),
        .hit_o        (hit),
        .insert_i     (grant && !hit),
        .insert_line_i(win_line)
    );
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        bus.OUT_reqReady = '0;
        if (grant) bus.OUT_reqReady[win] = 1'b1;
    end

    assign bus.OUT_prefetch = pf_q;
    assign bus.OUT_inflight = inflight_q;

    always_comb begin
        rr_d = rr_q;
        if (grant) rr_d = (int'(win) == NUM_SRC - 1) ? '0 : win + SRC_W'(1);

        pf_d = pf_q;
        if (bus.IN_flush)      pf_d.valid = 1'b0;
        else if (grant && !hit) begin
            pf_d.addr  = bus.IN_req[win].addr;
            pf_d.valid = 1'b1;
        end else if (hs)       pf_d.valid = 1'b0;

        inflight_d = inflight_q;
        if (inc && !ack_eff)      inflight_d = inflight_q + CNT_W'(1);
        else if (!inc && ack_eff) inflight_d = inflight_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            pf_q       <= '0;
            inflight_q <= '0;
        end else begin
            rr_q       <= rr_d;
            pf_q       <= pf_d;
            inflight_q <= inflight_d;
        end
    end
endmodule

// File: tb/tb_prefetch_scheduler.sv
module tb_prefetch_scheduler;
    import prefetch_scheduler_pkg::*;

    localparam int N = 2, MAXI = 4, FS = 8;
`ifdef PF_DEDUP_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prefetch_scheduler_if #(.NUM_SRC(N), .MAX_INFLIGHT(MAXI)) bus ();

    prefetch_scheduler #(.NUM_SRC(N), .MAX_INFLIGHT(MAXI), .FILTER_SIZE(FS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int chk_cnt = 0, pass_cnt = 0;

    // Reference model: current state (m_*) and next state (n_*).
    int          m_rr, m_inf, n_rr, n_inf;
    bit          m_pv, n_pv;
    logic [31:0] m_pa, n_pa;
    logic [25:0] m_filt[$], n_filt[$];
    logic [N-1:0] exp_rdy, obs_rdy;

    task automatic set_req(input int s, input logic [31:0] a, input bit v);
        bus.IN_req[s].addr  = a;
        bus.IN_req[s].valid = v;
    endtask

    task automatic set_idle();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 1'b0);
        bus.IN_prefetchReady     = 1'b1;
        bus.IN_prefetchAck.valid = 1'b0;
        bus.IN_flush             = 1'b0;
    endtask

    // Spec-level next-state computation from the current inputs.
    task automatic predict();
        int win;
        bit ack_eff, free, credit, grant, hs, hit;
        logic [31:0] a;
        exp_rdy = '0;
        n_rr = m_rr; n_inf = m_inf; n_pv = m_pv; n_pa = m_pa; n_filt = m_filt;
        if (rst) begin
            n_rr = 0; n_inf = 0; n_pv = 0; n_pa = 0; n_filt.delete();
            return;
        end
        ack_eff = bus.IN_prefetchAck.valid && m_inf > 0;
        free    = !m_pv || bus.IN_prefetchReady;
        credit  = (m_inf + int'(m_pv) < MAXI) || ack_eff;
        win = -1;
        for (int i = 0; i < N; i++)
            if (win < 0 && bus.IN_req[(m_rr + i) % N].valid) win = (m_rr + i) % N;
        grant = (win >= 0) && free && credit && !bus.IN_flush;
        hs    = m_pv && bus.IN_prefetchReady;
        n_inf = m_inf + ((hs && m_inf < MAXI) ? 1 : 0) - (ack_eff ? 1 : 0);
        hit = 1'b0;
        a = 32'h0;
        if (grant) begin
            a = bus.IN_req[win].addr;
            exp_rdy[win] = 1'b1;
            n_rr = (win + 1) % N;
            if (FILT_EN) foreach (m_filt[j]) if (m_filt[j] == a[31:6]) hit = 1'b1;
        end
        if (bus.IN_flush) begin
            n_pv = 0;
            n_filt.delete();
        end else if (grant && !hit) begin
            n_pv = 1; n_pa = a;
            if (FILT_EN) begin
                n_filt.push_back(a[31:6]);
                if (n_filt.size() > FS) void'(n_filt.pop_front());
            end
        end else if (hs) n_pv = 0;
    endtask

    // Inputs are set at posedge+1; sample ready at posedge+2, outputs at posedge+1.
    task automatic step();
        #1;
        predict();
        obs_rdy = bus.OUT_reqReady;
        @(posedge clk);
        m_rr = n_rr; m_inf = n_inf; m_pv = n_pv; m_pa = n_pa; m_filt = n_filt;
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        set_req(0, 32'h40, 1'b1);
        bus.IN_prefetchAck.valid = 1'b1;
        step(); step();
        chk_cnt++; if (obs_rdy !== 2'b00) $display("FAIL reset_ready got %b want 00", obs_rdy); else pass_cnt++;
        chk_cnt++; if (bus.OUT_prefetch.valid !== 1'b0) $display("FAIL reset_pv got %b want 0", bus.OUT_prefetch.valid); else pass_cnt++;
        chk_cnt++; if (bus.OUT_inflight !== 3'd0) $display("FAIL reset_inflight got %0d want 0", bus.OUT_inflight); else pass_cnt++;
        set_idle();
        bus.IN_prefetchAck.valid = 1'b1;
        step();
        chk_cnt++; if (obs_rdy !== 2'b00) $display("FAIL idle_ready got %b want 00", obs_rdy); else pass_cnt++;
        chk_cnt++; if (bus.OUT_inflight !== 3'd0) $display("FAIL stale_ack got %0d want 0", bus.OUT_inflight); else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 32'h1000, 1'b1);
        step();
        chk_cnt++; if (obs_rdy !== 2'b01) $display("FAIL single_ready got %b want 01", obs_rdy); else pass_cnt++;
        set_req(0, 32'h0, 1'b0);
        chk_cnt++; if (bus.OUT_prefetch !== {32'h1000, 1'b1}) $display("FAIL single_out got %h want %h", bus.OUT_prefetch, {32'h1000, 1'b1}); else pass_cnt++;
        step();
        chk_cnt++; if (bus.OUT_inflight !== 3'd1) $display("FAIL single_inflight got %0d want 1", bus.OUT_inflight); else pass_cnt++;
        chk_cnt++; if (bus.OUT_prefetch.valid !== 1'b0) $display("FAIL single_drain got %b want 0", bus.OUT_prefetch.valid); else pass_cnt++;
    endtask

    task automatic test_alternate();
        int cnt0 = 0, cnt1 = 0;
        logic [1:0] want;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_req(0, 32'h10000 + cnt0 * 32'h40, 1'b1);
            set_req(1, 32'h20000 + cnt1 * 32'h40, 1'b1);
            step();
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
            chk_cnt++; if (obs_rdy !== want) $display("FAIL rr_grant%0d got %b want %b", c, obs_rdy, want); else pass_cnt++;
            cnt0 += int'(obs_rdy[0]);
            cnt1 += int'(obs_rdy[1]);
        end
        set_idle();
        chk_cnt++; if (cnt0 != 2 || cnt1 != 2) $display("FAIL rr_counts got %0d,%0d want 2,2", cnt0, cnt1); else pass_cnt++;
    endtask

    task automatic test_credit();
        int grants = 0, k = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_req(0, 32'h40000 + k * 32'h40, 1'b1);
            step();
            if (obs_rdy[0]) begin grants++; k++; end
        end
        chk_cnt++; if (grants != 4) $display("FAIL credit_grants got %0d want 4", grants); else pass_cnt++;
        chk_cnt++; if (bus.OUT_inflight !== 3'd4) $display("FAIL credit_full got %0d want 4", bus.OUT_inflight); else pass_cnt++;
        set_req(0, 32'h40000 + k * 32'h40, 1'b1);
        bus.IN_prefetchAck.valid = 1'b1;
        step();
        chk_cnt++; if (obs_rdy !== 2'b01) $display("FAIL credit_ack_grant got %b want 01", obs_rdy); else pass_cnt++;
        k++;
        bus.IN_prefetchAck.valid = 1'b0;
        set_req(0, 32'h40000 + k * 32'h40, 1'b1);
        step();
        chk_cnt++; if (obs_rdy !== 2'b00) $display("FAIL credit_block got %b want 00", obs_rdy); else pass_cnt++;
        chk_cnt++; if (bus.OUT_inflight !== 3'd4) $display("FAIL credit_hold got %0d want 4", bus.OUT_inflight); else pass_cnt++;
        set_idle();
    endtask

    task automatic test_filter();
        int grants = 0;
        do_reset();
        set_req(0, 32'h2000, 1'b1);
        step();
        step();
        chk_cnt++; if (obs_rdy !== 2'b01) $display("FAIL dup_consumed got %b want 01", obs_rdy); else pass_cnt++;
        chk_cnt++; if (bus.OUT_prefetch.valid !== !FILT_EN) $display("FAIL dup_issue got %b want %b", bus.OUT_prefetch.valid, !FILT_EN); else pass_cnt++;
        set_req(0, 32'h0, 1'b0);
        step();
        chk_cnt++; if (bus.OUT_inflight !== (FILT_EN ? 3'd1 : 3'd2)) $display("FAIL dup_inflight got %0d want %0d", bus.OUT_inflight, FILT_EN ? 1 : 2); else pass_cnt++;
        bus.IN_prefetchAck.valid = 1'b1;
        for (int j = 0; j < 8; j++) begin
            set_req(0, 32'h50000 + j * 32'h40, 1'b1);
            step();
            grants += int'(obs_rdy[0]);
        end
        chk_cnt++; if (grants != 8) $display("FAIL filt_fill got %0d want 8", grants); else pass_cnt++;
        set_req(0, 32'h2000, 1'b1);
        step();
        chk_cnt++; if (bus.OUT_prefetch !== {32'h2000, 1'b1}) $display("FAIL evict_reissue got %h want %h", bus.OUT_prefetch, {32'h2000, 1'b1}); else pass_cnt++;
        set_idle();
    endtask

    task automatic test_stall();
        do_reset();
        set_req(0, 32'h6000, 1'b1);
        step();
        set_req(0, 32'h6040, 1'b1);
        bus.IN_prefetchReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_cnt++; if (obs_rdy !== 2'b00) $display("FAIL stall_ready%0d got %b want 00", c, obs_rdy); else pass_cnt++;
            chk_cnt++; if (bus.OUT_prefetch !== {32'h6000, 1'b1}) $display("FAIL stall_hold%0d got %h want %h", c, bus.OUT_prefetch, {32'h6000, 1'b1}); else pass_cnt++;
        end
        bus.IN_prefetchReady = 1'b1;
        step();
        chk_cnt++; if (obs_rdy !== 2'b01) $display("FAIL stall_release got %b want 01", obs_rdy); else pass_cnt++;
        chk_cnt++; if (bus.OUT_prefetch !== {32'h6040, 1'b1}) $display("FAIL stall_next got %h want %h", bus.OUT_prefetch, {32'h6040, 1'b1}); else pass_cnt++;
        chk_cnt++; if (bus.OUT_inflight !== 3'd1) $display("FAIL stall_inflight got %0d want 1", bus.OUT_inflight); else pass_cnt++;
        set_idle();
    endtask

    task automatic test_flush();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            set_req(0, 32'h3000 + j * 32'h40, 1'b1);
            step();
        end
        chk_cnt++; if (bus.OUT_inflight !== 3'd2 || bus.OUT_prefetch.valid !== 1'b1) $display("FAIL flush_setup got inf=%0d pv=%b want inf=2 pv=1", bus.OUT_inflight, bus.OUT_prefetch.valid); else pass_cnt++;
        set_req(0, 32'h0, 1'b0);
        bus.IN_prefetchReady = 1'b0;
        bus.IN_flush = 1'b1;
        step();
        chk_cnt++; if (bus.OUT_prefetch.valid !== 1'b0) $display("FAIL flush_pv got %b want 0", bus.OUT_prefetch.valid); else pass_cnt++;
        chk_cnt++; if (bus.OUT_inflight !== 3'd2) $display("FAIL flush_inflight got %0d want 2", bus.OUT_inflight); else pass_cnt++;
        bus.IN_flush = 1'b0;
        bus.IN_prefetchReady = 1'b1;
        set_req(0, 32'h3000, 1'b1);
        step();
        chk_cnt++; if (obs_rdy !== 2'b01) $display("FAIL flush_regrant got %b want 01", obs_rdy); else pass_cnt++;
        chk_cnt++; if (bus.OUT_prefetch !== {32'h3000, 1'b1}) $display("FAIL flush_reissue got %h want %h", bus.OUT_prefetch, {32'h3000, 1'b1}); else pass_cnt++;
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++)
                set_req(i, 32'h8000 + $urandom_range(0, 11) * 32'h40, $urandom_range(0, 9) < 6);
            bus.IN_prefetchReady     = ($urandom_range(0, 3) != 0);
            bus.IN_prefetchAck.valid = ($urandom_range(0, 2) == 0);
            bus.IN_flush             = ($urandom_range(0, 39) == 0);
            step();
            chk_cnt++; if (obs_rdy !== exp_rdy) $display("FAIL rnd_ready c%0d got %b want %b", c, obs_rdy, exp_rdy); else pass_cnt++;
            chk_cnt++; if (bus.OUT_prefetch.valid !== m_pv) $display("FAIL rnd_pv c%0d got %b want %b", c, bus.OUT_prefetch.valid, m_pv); else pass_cnt++;
            if (m_pv) begin
                chk_cnt++; if (bus.OUT_prefetch.addr !== m_pa) $display("FAIL rnd_addr c%0d got %h want %h", c, bus.OUT_prefetch.addr, m_pa); else pass_cnt++;
            end
            chk_cnt++; if (int'(bus.OUT_inflight) != m_inf) $display("FAIL rnd_inflight c%0d got %0d want %0d", c, bus.OUT_inflight, m_inf); else pass_cnt++;
        end
        set_idle();
    endtask

    initial begin
        m_rr = 0; m_inf = 0; m_pv = 0; m_pa = 0;
        set_idle();
        rst = 1'b1;
        test_reset();
        test_single();
        test_alternate();
        test_credit();
        test_filter();
        test_stall();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/prefetch_scheduler.md
# prefetch_scheduler

Arbitrates prefetch requests from several prefetch issuers onto the single cache prefetch port. It round-robins between sources, drops requests whose cache line was issued recently, and caps outstanding prefetches with a credit counter that is replenished by cache acknowledgements. It sits between the prefetch issuers and the load/store cache controller.

## Interface
Parameters:
- NUM_SRC, 2: number of requesting prefetch issuers.
- MAX_INFLIGHT, 4: maximum prefetches issued but not yet acknowledged.
- FILTER_SIZE, 8: entries in the recent-line filter (power of two).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- IN_req  in  Prefetch[NUM_SRC]  request per source: line-aligned addr, valid.
- OUT_reqReady  out  NUM_SRC  per source, request accepted this cycle.
- OUT_prefetch  out  Prefetch  registered request to cache.
- IN_prefetchReady  in  1  cache accepts OUT_prefetch this cycle.
- IN_prefetchAck  in  Prefetch_ACK  only .valid is used; one pulse per completed prefetch.
- IN_flush  in  1  clear filter and pending output; credits are kept.
- OUT_inflight  out  $clog2(MAX_INFLIGHT+1)  current outstanding count.

## Operation
- Output slot free = !OUT_prefetch.valid || IN_prefetchReady.
- Grant condition: slot free && credits available (inflight < MAX_INFLIGHT, or an ack arrives this cycle) && !IN_flush.
- Arbiter: round-robin over valid IN_req, starting at rrPtr. On a grant to source k, rrPtr <= k+1 mod NUM_SRC. rrPtr is unchanged when there is no grant.
- A granted request is consumed: OUT_reqReady[k]=1. Non-granted sources see 0 and hold their request.
- Filter hit (addr matches a valid filter entry): the request is consumed (ready=1). It is dropped: no issue, no credit used, rrPtr advances. Only the winner is checked.
- Filter miss: OUT_prefetch <= {addr, valid:1}. The addr is written into the filter at wrPtr, and wrPtr increments (FIFO replacement, wraps at FILTER_SIZE).
- The inflight counter increments when OUT_prefetch handshakes (valid && IN_prefetchReady). It decrements on ack.valid. Both in the same cycle leave it unchanged. An ack at inflight==0 is ignored (saturates at 0). The increment never exceeds MAX_INFLIGHT.
- Credits are reserved at issue into the output register: the counter compared against MAX_INFLIGHT is inflight plus OUT_prefetch.valid.
- IN_flush: OUT_prefetch.valid <= 0, all filter entries invalid, no grant that cycle. inflight is unaffected, because acks for requests already issued still arrive.
- Unchanged inputs give no grant when there is no valid request.

## Timing
- Reset: OUT_prefetch.valid=0, OUT_reqReady=0, OUT_inflight=0, rrPtr=0, wrPtr=0, filter invalid.
- OUT_reqReady is combinational from IN_req, state and IN_prefetchReady.
- Latency: granted in cycle N, so OUT_prefetch is valid in cycle N+1. Back-to-back issue happens every cycle while the cache is ready and credits remain.
- OUT_prefetch holds stable while valid && !IN_prefetchReady.
- Ack in cycle N frees the credit for a grant in cycle N itself.
- Reset mid-operation discards the pending output and counters. Acks arriving after reset are ignored by saturation.

## Configuration
- PF_DEDUP_FILTER_EN defined: the recent-line filter is present as described.
- Not defined: no filter storage. Every granted request is issued, and IN_flush only clears OUT_prefetch.valid.

## Structure
- The shared package gets Prefetch, Prefetch_ACK (already present), and a new PFLine_t line-address typedef used for filter entries.
- One sub-module, prefetch_line_filter: FIFO-replacement CAM with lookup, insert and clear ports. It is instantiated only under PF_DEDUP_FILTER_EN.
- The round-robin grant reuses the existing PriorityEncoder on a rotated request vector.

## Test plan
- Single source, addr 0x1000, cache always ready: OUT_prefetch is valid with 0x1000 one cycle later, and inflight goes to 1.
- Both sources valid for 4 cycles with distinct addresses: grants alternate 0,1,0,1, and each source is ready exactly twice.
- MAX_INFLIGHT=4, no acks, 6 distinct requests: exactly 4 are issued. The 5th is granted in the same cycle an ack pulses, and inflight stays at 4.
- With the filter enabled, request 0x2000, then 0x2000 again: the second is consumed with no OUT_prefetch and inflight unchanged. After 8 other distinct lines, 0x2000 is issued again.
- Cache not ready for 3 cycles: OUT_prefetch is held stable and OUT_reqReady is all 0. Then ready: it issues, and the next grant occurs the same cycle.
- IN_flush with a pending output and inflight=2: valid drops next cycle and inflight stays 2. A previously filtered line 0x3000 is issued afterwards.
